// File: rtl/restador_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   estado_t : FSM states (REPOSO, RESTANDO, FIN)
//   N_DEF    : default operand / difference width
package restador_serial_pkg;

  localparam int unsigned N_DEF = 8;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    RESTANDO = 2'd1,
    FIN      = 2'd2
  } estado_t;

endpackage

// File: rtl/restador_serial_completo.sv
// Combinational full subtractor built from two half-subtractor stages.
//   x, y : minuend / subtrahend bits
//   pin  : incoming borrow
//   R    : difference bit   (x ^ y ^ pin)
//   P    : outgoing borrow  ((~x & y) | (~(x ^ y) & pin))
module restador_completo (
  input  logic x,
  input  logic y,
  input  logic pin,
  output logic R,
  output logic P
);

  logic d1;
  logic p1;
  logic p2;

  // First stage: x - y
  assign d1 = x ^ y;
  assign p1 = ~x & y;

  // Second stage: (x - y) - pin
  assign R  = d1 ^ pin;
  assign p2 = ~d1 & pin;

  assign P  = p1 | p2;

endmodule

// File: rtl/restador_serial.sv
// Bit-serial unsigned subtractor: diferencia = a - b mod 2^N, one bit per
// cycle LSB first, with the final borrow reported on prestamo.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   inicio     : start request, honoured only in REPOSO
//   a, b       : operands, captured on the start-accept edge
//   ocupado    : high in RESTANDO and FIN
//   listo      : one-cycle pulse while the result is first valid
//   diferencia : result, held until the next start is accepted
//   prestamo   : final borrow (1 when a < b)
module restador_serial
  import restador_serial_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ocupado,
  output logic         listo,
  output logic [N-1:0] diferencia,
  output logic         prestamo
);

  localparam int unsigned CW = $clog2(N);

  estado_t       estado;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res_sr;
  logic [CW-1:0] cnt;
  logic          borrow;
  logic          r_bit;
  logic          p_bit;

  restador_completo u_completo (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .pin (borrow),
    .R   (r_bit),
    .P   (p_bit)
  );

  // Sequencer: operand capture, serial shift and result publication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= REPOSO;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      ocupado    <= 1'b0;
      listo      <= 1'b0;
      diferencia <= '0;
      prestamo   <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          listo <= 1'b0;
          if (inicio) begin
            a_sr    <= a;
            b_sr    <= b;
            borrow  <= 1'b0;
            cnt     <= '0;
            ocupado <= 1'b1;
            estado  <= RESTANDO;
          end
        end
        RESTANDO: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {r_bit, res_sr[N-1:1]};
          borrow <= p_bit;
          cnt    <= cnt + CW'(1);
          // Last bit: publish the completed word together with listo
          if (cnt == CW'(N - 1)) begin
            diferencia <= {r_bit, res_sr[N-1:1]};
            prestamo   <= p_bit;
            listo      <= 1'b1;
            estado     <= FIN;
          end
        end
        FIN: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial: table-driven vectors, hand-written
// abort / ignored-start sequences and a back-to-back random run, all checked
// through a scoreboard of expected results and expected listo cycles.
module tb_restador_serial;

  localparam int unsigned N = 8;

  logic         clk;
  logic         reset;
  logic         inicio;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         ocupado;
  logic         listo;
  logic [N-1:0] diferencia;
  logic         prestamo;

  restador_serial #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .inicio     (inicio),
    .a          (a_i),
    .b          (b_i),
    .ocupado    (ocupado),
    .listo      (listo),
    .diferencia (diferencia),
    .prestamo   (prestamo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic         p;
  } vec_t;

  typedef struct {
    logic [N-1:0] d;
    logic         p;
    int           exp_cyc;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_listo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every listo pulse must match the oldest outstanding start
  always @(negedge clk) begin
    if (listo) begin
      sb_t e;
      n_listo++;
      if (sb.size() == 0) begin
        chk("unexpected_listo", 32'(listo), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("diferencia", 32'(diferencia), 32'(e.d));
        chk("prestamo", 32'(prestamo), 32'(e.p));
        chk("listo_latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  // Drive a start at the next negedge; the following posedge accepts it
  task automatic start(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] d, input logic p);
    sb_t e;
    @(negedge clk);
    a_i = a;
    b_i = b;
    inicio = 1'b1;
    e.d = d;
    e.p = p;
    e.exp_cyc = cyc + 1 + int'(N);
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4 * int'(N)) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      chk("timeout_waiting_listo", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic release_and_wait();
    @(negedge clk);
    inicio = 1'b0;
    chk("ocupado_running", 32'(ocupado), 32'd1);
    wait_done();
  endtask

  vec_t vecs[6];

  initial begin
    int base;
    logic [N:0] full;

    vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, p: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, d: 8'hFF, p: 1'b1};
    vecs[2] = '{a: 8'hAA, b: 8'hAA, d: 8'h00, p: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, p: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h7F, d: 8'h01, p: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'hFF, d: 8'h02, p: 1'b1};

    reset = 1'b1;
    inicio = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_listo", 32'(listo), 32'd0);
    chk("rst_diferencia", 32'(diferencia), 32'd0);
    chk("rst_prestamo", 32'(prestamo), 32'd0);
    reset = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 6; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].p);
      release_and_wait();
      @(negedge clk);
      chk("ocupado_idle", 32'(ocupado), 32'd0);
    end

    // Result holds while idle
    base = n_listo;
    repeat (4) @(negedge clk);
    chk("hold_diferencia", 32'(diferencia), 32'h02);
    chk("hold_prestamo", 32'(prestamo), 32'd1);
    chk("hold_no_listo", 32'(n_listo - base), 32'd0);

    // Start request during RESTANDO is ignored; operands may change freely
    base = n_listo;
    start(8'h10, 8'h01, 8'h0F, 1'b0);
    @(negedge clk);
    inicio = 1'b0;
    a_i = 8'h33;
    b_i = 8'h44;
    repeat (2) @(negedge clk);
    inicio = 1'b1;
    a_i = 8'h80;
    b_i = 8'h7F;
    @(negedge clk);
    inicio = 1'b0;
    wait_done();
    repeat (2 * N) @(negedge clk);
    chk("single_listo_pulse", 32'(n_listo - base), 32'd1);
    chk("ignored_start_idle", 32'(ocupado), 32'd0);

    // Reset mid-operation aborts with no listo; first edge after release accepts
    base = n_listo;
    start(8'h20, 8'h01, 8'h1F, 1'b0);
    @(negedge clk);
    inicio = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_diferencia", 32'(diferencia), 32'd0);
    chk("abort_listo", 32'(listo), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    begin
      sb_t e;
      a_i = 8'h09;
      b_i = 8'h04;
      inicio = 1'b1;
      e.d = 8'h05;
      e.p = 1'b0;
      e.exp_cyc = cyc + 1 + int'(N);
      sb.push_back(e);
    end
    release_and_wait();
    chk("abort_listo_count", 32'(n_listo - base), 32'd1);

    // Back-to-back random operations with inicio held high
    @(negedge clk);
    @(negedge clk);
    inicio = 1'b1;
    for (int j = 0; j < 1000; j++) begin
      sb_t e;
      a_i = N'($urandom);
      b_i = N'($urandom);
      full = {1'b0, a_i} - {1'b0, b_i};
      e.d = full[N-1:0];
      e.p = full[N];
      e.exp_cyc = cyc + 1 + int'(N);
      sb.push_back(e);
      for (int k = 0; k < int'(N) + 1; k++) begin
        @(negedge clk);
        a_i = N'($urandom);
        b_i = N'($urandom);
      end
      @(negedge clk);
    end
    inicio = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("random_ocupado_idle", 32'(ocupado), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
